// File: rtl/riscv_alu_pkg.sv
// ---------------------------------------------------------------------------
// riscv_alu_pkg
// Shared definitions for the execute-stage ALU:
//   - XLEN_DEFAULT       default operand/result width
//   - ALU_ADD..ALU_SRA   3-bit op codes, same encoding as alu_control emits
//   - alu_state_t        FSM encoding (ST_IDLE / ST_SHIFT) used by the
//                        serial-shift build of ex_alu_stage
//   - is_shift_op()      true for SLL/SRL/SRA
// ---------------------------------------------------------------------------
package riscv_alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;
    localparam logic [2:0] ALU_SLL = 3'd5;
    localparam logic [2:0] ALU_SRL = 3'd6;
    localparam logic [2:0] ALU_SRA = 3'd7;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } alu_state_t;

    function automatic logic is_shift_op(input logic [2:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/ex_alu_stage_if.sv
// ---------------------------------------------------------------------------
// ex_alu_stage_if
// Bundles the ID/EX input handshake, the flush line and the EX/MEM output
// handshake of the execute stage.
//   Input side : in_valid, in_ready, alu_ctrl, op_a, op_b, rd, reg_write
//   Control    : flush
//   Output side: out_valid, out_ready, out_result, out_zero, out_rd,
//                out_reg_write
// Modports:
//   master - the pipeline around the stage (drives operands, flush, out_ready)
//   slave  - the execute stage itself
// ---------------------------------------------------------------------------
interface ex_alu_stage_if
    import riscv_alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      alu_ctrl;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [4:0]      rd;
    logic            reg_write;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic            out_zero;
    logic [4:0]      out_rd;
    logic            out_reg_write;

    modport master (
        output in_valid, alu_ctrl, op_a, op_b, rd, reg_write, flush, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_rd, out_reg_write
    );

    modport slave (
        input  in_valid, alu_ctrl, op_a, op_b, rd, reg_write, flush, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_rd, out_reg_write
    );

endinterface

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
// Purely combinational RV32-style ALU: result and zero flag for all eight
// op codes.
// Parameters:
//   XLEN    operand/result width
//   BARREL  1: shifts use a single-cycle barrel shifter
//           0: shift ops return op_a unchanged (the shift-by-zero result);
//              used when shifting is done serially elsewhere
// Ports:
//   alu_ctrl in  3     op code (riscv_alu_pkg ALU_*)
//   op_a     in  XLEN  first operand
//   op_b     in  XLEN  second operand, low log2(XLEN) bits are the shamt
//   result   out XLEN  ALU result
//   zero     out 1     result == 0
// ---------------------------------------------------------------------------
module alu_core
    import riscv_alu_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter bit BARREL = 1'b1
) (
    input  logic [2:0]      alu_ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;
    logic        [XLEN-1:0] sll_r;
    logic        [XLEN-1:0] srl_r;
    logic        [XLEN-1:0] sra_r;

    assign a_s = op_a;
    assign b_s = op_b;

    generate
        if (BARREL) begin : g_barrel
            localparam int SHW = $clog2(XLEN);
            logic [SHW-1:0] shamt;

            // Upper op_b bits are ignored for shifts.
            assign shamt = op_b[SHW-1:0];
            assign sll_r = op_a << shamt;
            assign srl_r = op_a >> shamt;
            assign sra_r = a_s >>> shamt;
        end else begin : g_no_barrel
            assign sll_r = op_a;
            assign srl_r = op_a;
            assign sra_r = op_a;
        end
    endgenerate

    always_comb begin
        result = '0;
        case (alu_ctrl)
            ALU_ADD: result = op_a + op_b;
            ALU_SUB: result = op_a - op_b;
            ALU_AND: result = op_a & op_b;
            ALU_OR:  result = op_a | op_b;
            ALU_SLT: result = {{(XLEN-1){1'b0}}, (a_s < b_s)};
            ALU_SLL: result = sll_r;
            ALU_SRL: result = srl_r;
            ALU_SRA: result = sra_r;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/ex_alu_stage.sv
// ---------------------------------------------------------------------------
// ex_alu_stage
// Execute stage of the 5-stage RISC-V pipeline. Computes the ALU result and
// zero flag for the op from ID/EX and holds it in a one-entry EX/MEM output
// register behind a valid/ready handshake. rd and reg_write ride along.
//
// Build option:
//   SERIAL_SHIFT_EN  defined   : SLL/SRL/SRA with shamt > 0 run on a
//                                1-bit-per-cycle shifter (SHIFT state +
//                                counter), stalling ID/EX while busy.
//                    undefined : every op, shifts included, completes in one
//                                cycle through the barrel shifter.
//
// Ports:
//   clk    in  single clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    ex_alu_stage_if.slave:
//            in_valid/in_ready   ID/EX handshake (in_ready is combinational
//                                from state and out_ready)
//            alu_ctrl, op_a, op_b, rd, reg_write   instruction fields
//            flush               kills the presented input and any serial
//                                shift in progress; the held output stays
//            out_valid/out_ready EX/MEM handshake
//            out_result, out_zero, out_rd, out_reg_write   registered outputs
// ---------------------------------------------------------------------------
module ex_alu_stage
    import riscv_alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    ex_alu_stage_if.slave bus
);

    logic            out_free;
    logic            accept;
    logic            load;
    logic [XLEN-1:0] load_result;
    logic            load_zero;
    logic [4:0]      load_rd;
    logic            load_reg_write;
    logic [XLEN-1:0] core_result;
    logic            core_zero;

    logic            vld_p1;
    logic [XLEN-1:0] result_p1;
    logic            zero_p1;
    logic [4:0]      rd_p1;
    logic            reg_write_p1;

    // The output entry can take a new result if empty or draining this cycle.
    assign out_free = !vld_p1 || bus.out_ready;
    // A flush discards whatever is presented in the same cycle.
    assign accept   = bus.in_valid && bus.in_ready && !bus.flush;

`ifdef SERIAL_SHIFT_EN
    localparam bit USE_BARREL = 1'b0;
`else
    localparam bit USE_BARREL = 1'b1;
`endif

    alu_core #(
        .XLEN   (XLEN),
        .BARREL (USE_BARREL)
    ) u_alu_core (
        .alu_ctrl (bus.alu_ctrl),
        .op_a     (bus.op_a),
        .op_b     (bus.op_b),
        .result   (core_result),
        .zero     (core_zero)
    );

`ifdef SERIAL_SHIFT_EN
    localparam int SHW = $clog2(XLEN);

    alu_state_t      state_q;
    alu_state_t      state_d;
    logic [SHW-1:0]  cnt_q;
    logic [XLEN-1:0] sh_data_q;
    logic [2:0]      sh_op_q;
    logic [4:0]      sh_rd_q;
    logic            sh_reg_write_q;
    logic [XLEN-1:0] sh_next;
    logic            start_shift;
    logic            shift_done;
    logic            ready_int;

    function automatic logic [XLEN-1:0] shift_step(input logic [2:0]      op,
                                                   input logic [XLEN-1:0] v);
        case (op)
            ALU_SLL: return {v[XLEN-2:0], 1'b0};
            ALU_SRA: return {v[XLEN-1], v[XLEN-1:1]};
            default: return {1'b0, v[XLEN-1:1]};
        endcase
    endfunction

    // Shift by zero is just op_a, so it goes through the one-cycle path.
    assign start_shift = accept && is_shift_op(bus.alu_ctrl)
                         && (bus.op_b[SHW-1:0] != '0);
    assign sh_next     = shift_step(sh_op_q, sh_data_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_shift) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bus.flush || (cnt_q == SHW'(1))) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ready_int  = 1'b0;
        shift_done = 1'b0;
        case (state_q)
            ST_IDLE:  ready_int  = out_free;
            // The last shift step is the one that writes the output entry.
            ST_SHIFT: shift_done = !bus.flush && (cnt_q == SHW'(1));
            default: begin
                ready_int  = 1'b0;
                shift_done = 1'b0;
            end
        endcase
    end

    assign bus.in_ready = ready_int;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (bus.flush) begin
            cnt_q <= '0;
        end else if (start_shift) begin
            cnt_q <= bus.op_b[SHW-1:0];
        end else if (state_q == ST_SHIFT) begin
            cnt_q <= cnt_q - SHW'(1);
        end
    end

    // ---- serial shift stage: operand and sideband latched at accept ----
    always_ff @(posedge clk) begin
        if (start_shift) begin
            sh_data_q      <= bus.op_a;
            sh_op_q        <= bus.alu_ctrl;
            sh_rd_q        <= bus.rd;
            sh_reg_write_q <= bus.reg_write;
        end else if (state_q == ST_SHIFT) begin
            sh_data_q <= sh_next;
        end
    end

    // While SHIFT is busy in_ready is low, so the two load sources never
    // coincide and the output entry is already empty at completion.
    assign load = (accept && !start_shift) || shift_done;

    always_comb begin
        if (shift_done) begin
            load_result    = sh_next;
            load_zero      = (sh_next == '0);
            load_rd        = sh_rd_q;
            load_reg_write = sh_reg_write_q;
        end else begin
            load_result    = core_result;
            load_zero      = core_zero;
            load_rd        = bus.rd;
            load_reg_write = bus.reg_write;
        end
    end
`else
    assign bus.in_ready   = out_free;
    assign load           = accept;
    assign load_result    = core_result;
    assign load_zero      = core_zero;
    assign load_rd        = bus.rd;
    assign load_reg_write = bus.reg_write;
`endif

    // ---- EX/MEM output register (p1) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1       <= 1'b0;
            result_p1    <= '0;
            zero_p1      <= 1'b0;
            rd_p1        <= '0;
            reg_write_p1 <= 1'b0;
        end else if (load) begin
            vld_p1       <= 1'b1;
            result_p1    <= load_result;
            zero_p1      <= load_zero;
            rd_p1        <= load_rd;
            reg_write_p1 <= load_reg_write;
        end else if (vld_p1 && bus.out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign bus.out_valid     = vld_p1;
    assign bus.out_result    = result_p1;
    assign bus.out_zero      = zero_p1;
    assign bus.out_rd        = rd_p1;
    assign bus.out_reg_write = reg_write_p1;

endmodule

// File: tb/tb_ex_alu_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_alu_stage
// Scoreboard bench for ex_alu_stage: the driver pushes the expected response
// of every accepted op into a queue, a monitor pops and compares on every
// EX/MEM transfer. Directed cases cover reset, latency, back-pressure and
// flush; a randomized phase follows with random out_ready.
// ---------------------------------------------------------------------------
module tb_ex_alu_stage;
    import riscv_alu_pkg::*;

    localparam int XLEN = 32;

    typedef struct {
        logic [31:0] result;
        logic        zero;
        logic [4:0]  rd;
        logic        rw;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    ex_alu_stage_if #(.XLEN(XLEN)) bus ();

    ex_alu_stage #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   rand_ready = 1'b0;
    logic ready_force = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    // Reference model straight from the ISA rules, shifts as arithmetic.
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] r,
                                   input logic rw);
        exp_t        e;
        int          sh;
        logic [31:0] p2;
        sh = int'(b[4:0]);
        p2 = 32'd1 << sh;
        case (op)
            ALU_ADD: e.result = a + b;
            ALU_SUB: e.result = a - b;
            ALU_AND: e.result = a & b;
            ALU_OR:  e.result = a | b;
            ALU_SLT: e.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLL: e.result = 32'(64'(a) * 64'(p2));
            ALU_SRL: e.result = a / p2;
            default: e.result = a[31] ? ~((~a) / p2) : (a / p2);
        endcase
        e.zero = (e.result == 32'd0);
        e.rd   = r;
        e.rw   = rw;
        return e;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Called just after a rising edge; returns just after the accepting edge
    // with in_valid dropped.
    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r, input logic rw, input bit expect_out);
        int waited = 0;
        bus.in_valid  = 1'b1;
        bus.alu_ctrl  = op;
        bus.op_a      = a;
        bus.op_b      = b;
        bus.rd        = r;
        bus.reg_write = rw;
        forever begin
            @(negedge clk);
            if (bus.in_ready && !bus.flush) begin
                if (expect_out) sb_q.push_back(model(op, a, b, r, rw));
                break;
            end
            waited++;
            if (waited > 200) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: in_ready low for %0d cycles, required accept", waited);
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // out_ready driver (sole writer)
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            bus.out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
        end
    end

    // Monitor: every EX/MEM transfer must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got result 0x%08h, required no output", bus.out_result);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_result", bus.out_result, e.result);
                    check("sb_zero", 32'(bus.out_zero), 32'(e.zero));
                    check("sb_rd", 32'(bus.out_rd), 32'(e.rd));
                    check("sb_reg_write", 32'(bus.out_reg_write), 32'(e.rw));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int low_rdy;
        int seen;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        bus.in_valid  = 1'b0;
        bus.alu_ctrl  = 3'd0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.rd        = '0;
        bus.reg_write = 1'b0;
        bus.flush     = 1'b0;
        rst_n         = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_result", bus.out_result, 32'd0);
        check("rst_out_zero", 32'(bus.out_zero), 32'd0);
        check("rst_out_rd", 32'(bus.out_rd), 32'd0);
        check("rst_out_reg_write", 32'(bus.out_reg_write), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ADD 5+7, one-cycle latency
        send(ALU_ADD, 32'd5, 32'd7, 5'd1, 1'b1, 1'b1);
        @(negedge clk);
        check("add_latency_valid", 32'(bus.out_valid), 32'd1);
        @(posedge clk);
        #1;

        send(ALU_SUB, 32'd9, 32'd9, 5'd2, 1'b1, 1'b1);
        send(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 5'd3, 1'b1, 1'b1);

        // SRA by 4 with junk in the ignored op_b bits
        send(ALU_SRA, 32'h8000_0000, 32'hFFFF_FFE4, 5'd4, 1'b1, 1'b1);
        lat     = 0;
        low_rdy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (!bus.in_ready) low_rdy++;
            if (bus.out_valid) break;
        end
`ifdef SERIAL_SHIFT_EN
        check("sra_latency", 32'(lat), 32'd5);
        check("sra_in_ready_low", 32'(low_rdy), 32'd4);
`else
        check("sra_latency", 32'(lat), 32'd1);
        check("sra_in_ready_low", 32'(low_rdy), 32'd0);
`endif
        @(posedge clk);
        #1;

        // Back-pressure: held result must stay put and block new input
        ready_force = 1'b0;
        send(ALU_ADD, 32'd100, 32'd23, 5'd7, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_out_result", bus.out_result, 32'd123);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        ready_force = 1'b1;
        send(ALU_ADD, 32'd1000, 32'd1, 5'd8, 1'b0, 1'b1);
        @(negedge clk);
        check("b2b_out_valid", 32'(bus.out_valid), 32'd1);
        check("b2b_out_result", bus.out_result, 32'd1001);
        @(posedge clk);
        #1;

        // Flush with an input presented: the input is discarded
        send(ALU_ADD, 32'd1, 32'd2, 5'd3, 1'b1, 1'b1);
        bus.in_valid = 1'b1;
        bus.alu_ctrl = ALU_SLL;
        bus.op_a     = 32'h0000_00FF;
        bus.op_b     = 32'd10;
        bus.flush    = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("flush_discard_valid", 32'(bus.out_valid), 32'd0);
        check("flush_discard_result", bus.out_result, 32'd3);
        @(posedge clk);
        #1;

`ifdef SERIAL_SHIFT_EN
        // Flush during a 10-step SLL, third cycle of the shift
        send(ALU_SLL, 32'h0000_00FF, 32'd10, 5'd9, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        @(negedge clk);
        check("flush_shift_in_ready", 32'(bus.in_ready), 32'd1);
        check("flush_shift_valid", 32'(bus.out_valid), 32'd0);
        check("flush_shift_result", bus.out_result, 32'd3);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("flush_shift_no_result", 32'(seen), 32'd0);
        @(posedge clk);
        #1;
`endif

        // Randomized phase
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = ($urandom_range(0, 3) == 0) ? pick_operand() : $urandom;
            send(op, a, b, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'b1);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_ready = 1'b0;
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
